// File: rtl/load_store_unit_if.sv
// ============================================================================
// Module   : load_store_unit_if
// Purpose  : Request, data-memory bus and response signals of the load/store unit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] load_data;

  // master: the load/store unit; slave: execute stage plus data memory
  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
           resp_valid, resp_err, load_data
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
           resp_valid, resp_err, load_data
  );
endinterface

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module   : load_store_unit
// Purpose  : RV32I memory stage, single outstanding word bus access with timeout.
//            Define MISALIGN_TRAP_EN to reject misaligned half/word accesses.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  load_store_unit_if.master         bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [16:0] TIMEOUT_C = 17'(TIMEOUT);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] load_data_q, load_data_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;

  logic        legal;
  logic        misaligned;
  logic [1:0]  off_eff;
  logic [3:0]  wstrb_new;
  logic [31:0] wdata_new;
  logic [31:0] rdata_shift;
  logic [15:0] rdata_half;
  logic [31:0] load_ext;
  logic [16:0] cnt_inc;

  // Request decode: legality, alignment, lane placement of store data
  always_comb begin
    if (bus.req_we)
      legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
              (bus.req_funct3 == 3'b010);
    else
      legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
              (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
              (bus.req_funct3 == 3'b101);
`ifdef MISALIGN_TRAP_EN
    misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                 ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif
    off_eff   = 2'b00;
    wstrb_new = 4'b0000;
    wdata_new = bus.req_wdata;
    case (bus.req_funct3[1:0])
      2'b00: begin
        off_eff   = bus.req_addr[1:0];
        wstrb_new = 4'b0001 << bus.req_addr[1:0];
        wdata_new = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        off_eff   = {bus.req_addr[1], 1'b0};
        wstrb_new = 4'b0011 << {bus.req_addr[1], 1'b0};
        wdata_new = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        off_eff   = 2'b00;
        wstrb_new = 4'b1111;
        wdata_new = bus.req_wdata;
      end
    endcase
    if (!bus.req_we)
      wstrb_new = 4'b0000;
  end

  // Load extraction from the latched offset and size
  always_comb begin
    rdata_shift = bus.mem_rdata >> {off_q, 3'b000};
    rdata_half  = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      3'b100:  load_ext = {24'd0, rdata_shift[7:0]};
      3'b001:  load_ext = {{16{rdata_half[15]}}, rdata_half};
      3'b101:  load_ext = {16'd0, rdata_half};
      default: load_ext = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    load_data_d  = load_data_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    cnt_inc      = {1'b0, cnt_q} + 17'd1;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (!legal || misaligned) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            load_data_d  = 32'd0;
          end else begin
            state_d     = ST_ACCESS;
            cnt_d       = 16'd0;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.req_we;
            mem_addr_d  = {bus.req_addr[31:2], 2'b00};
            mem_wstrb_d = wstrb_new;
            mem_wdata_d = wdata_new;
            funct3_d    = bus.req_funct3;
            off_d       = off_eff;
          end
        end
      end
      ST_ACCESS: begin
        // An ack in the expiry cycle still completes successfully
        if (bus.mem_ack) begin
          state_d      = ST_RESP;
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          mem_wstrb_d  = 4'b0000;
          resp_valid_d = 1'b1;
          load_data_d  = mem_we_q ? 32'd0 : load_ext;
        end else if (cnt_inc == TIMEOUT_C) begin
          state_d      = ST_RESP;
          cnt_d        = cnt_inc[15:0];
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          mem_wstrb_d  = 4'b0000;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          load_data_d  = 32'd0;
        end else begin
          cnt_d = cnt_inc[15:0];
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 16'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wstrb_q  <= 4'd0;
      mem_wdata_q  <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      load_data_q  <= 32'd0;
      funct3_q     <= 3'd0;
      off_q        <= 2'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      load_data_q  <= load_data_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE) && !rst;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wstrb  = mem_wstrb_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.load_data  = load_data_q;

endmodule

`default_nettype wire
